// File: rtl/router_pkt_src.sv
`default_nettype none
// ============================================================================
// router_pkt_src : buffers one command + payload, then drives a contiguous
//                  header/payload/parity packet into router_top.
// Rev 1.0
// ============================================================================
module router_pkt_src #(
  parameter int LEN_W   = 6,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_err,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic             busy,
  output logic             packet_valid,
  output logic [7:0]       pkt_data,
  output logic             done,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int DEPTH = (1 << LEN_W) - 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HDR  = 3'd2,
    S_PLD  = 3'd3,
    S_PAR  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_q, wr_d;
  logic [LEN_W-1:0] rd_q, rd_d;
  logic [7:0]       parity_q, parity_d;
  logic             packet_valid_q, packet_valid_d;
  logic [7:0]       pkt_data_q, pkt_data_d;
  logic             done_q, done_d;
  logic             cmd_err_q, cmd_err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [7:0]       buf_q [0:DEPTH-1];
  logic             buf_we;
  logic [7:0]       hdr_cmd;
  logic [7:0]       hdr_lat;
  logic [LEN_W-1:0] wr_nxt;
  logic [LEN_W-1:0] rd_nxt;

  // Header is {len, addr}; sized for LEN_W=6 so it fills exactly one byte.
  assign hdr_cmd = 8'({cmd_len, cmd_addr});
  assign hdr_lat = 8'({len_q, addr_q});
  assign wr_nxt  = wr_q + 1'b1;
  assign rd_nxt  = rd_q + 1'b1;

  assign cmd_ready    = (state_q == S_IDLE);
  assign pl_ready     = (state_q == S_LOAD);
  assign packet_valid = packet_valid_q;
  assign pkt_data     = pkt_data_q;
  assign done         = done_q;
  assign cmd_err      = cmd_err_q;
  assign pkt_cnt      = pkt_cnt_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    wr_d           = wr_q;
    rd_d           = rd_q;
    parity_d       = parity_q;
    packet_valid_d = packet_valid_q;
    pkt_data_d     = pkt_data_q;
    done_d         = 1'b0;
    cmd_err_d      = 1'b0;
    pkt_cnt_d      = pkt_cnt_q;
    gap_d          = gap_q;
    buf_we         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr == 2'd3 || cmd_len == '0) begin
            cmd_err_d = 1'b1;
          end else begin
            addr_d   = cmd_addr;
            len_d    = cmd_len;
            parity_d = hdr_cmd;
            wr_d     = '0;
            rd_d     = '0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pl_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ pl_data;
          wr_d     = wr_nxt;
          // Only start emitting once the whole payload is buffered, so
          // upstream gaps can never break packet_valid contiguity.
          if (wr_nxt == len_q) begin
            packet_valid_d = 1'b1;
            pkt_data_d     = hdr_lat;
            state_d        = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          pkt_data_d = buf_q[0];
          state_d    = S_PLD;
        end
      end
      S_PLD: begin
        if (!busy) begin
          if (rd_nxt != len_q) begin
            pkt_data_d = buf_q[rd_nxt];
            rd_d       = rd_nxt;
          end else begin
            packet_valid_d = 1'b0;
            pkt_data_d     = parity_q;
            state_d        = S_PAR;
          end
        end
      end
      S_PAR: begin
        if (!busy) begin
          done_d     = 1'b1;
          pkt_cnt_d  = pkt_cnt_q + 1'b1;
          pkt_data_d = 8'h00;
          gap_d      = '0;
          state_d    = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      parity_q       <= '0;
      packet_valid_q <= 1'b0;
      pkt_data_q     <= '0;
      done_q         <= 1'b0;
      cmd_err_q      <= 1'b0;
      pkt_cnt_q      <= '0;
      gap_q          <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      parity_q       <= parity_d;
      packet_valid_q <= packet_valid_d;
      pkt_data_q     <= pkt_data_d;
      done_q         <= done_d;
      cmd_err_q      <= cmd_err_d;
      pkt_cnt_q      <= pkt_cnt_d;
      gap_q          <= gap_d;
    end
  end

  // Payload storage carries no reset; contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_q] <= pl_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_src.sv
`default_nettype none
// ============================================================================
// tb_router_pkt_src : directed self-checking bench for router_pkt_src.
// Rev 1.0
// ============================================================================
module tb_router_pkt_src;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       busy;

  logic        cmd_ready, cmd_err, pl_ready, packet_valid, done;
  logic [7:0]  pkt_data;
  logic [15:0] pkt_cnt;

  logic        cmd_ready_w, cmd_err_w, pl_ready_w, packet_valid_w, done_w;
  logic [7:0]  pkt_data_w;
  logic [1:0]  pkt_cnt_w;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [7:0] pl_mem [64];

  router_pkt_src #(.LEN_W(6), .GAP_CYC(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_err(cmd_err),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .busy(busy), .packet_valid(packet_valid), .pkt_data(pkt_data),
    .done(done), .pkt_cnt(pkt_cnt)
  );

  // Narrow-counter twin sharing the same stimulus, used to observe counter wrap.
  router_pkt_src #(.LEN_W(6), .GAP_CYC(2), .CNT_W(2)) u_dut_w (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_err(cmd_err_w),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready_w),
    .busy(busy), .packet_valid(packet_valid_w), .pkt_data(pkt_data_w),
    .done(done_w), .pkt_cnt(pkt_cnt_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one packet and checks every output cycle; hdr/par are hand-computed by the caller.
  task automatic run_pkt(input logic [1:0] a, input int len, input bit gapped,
                         input int stall_pos, input int stall_n,
                         input logic [7:0] hdr, input logic [7:0] par);
    logic [7:0] exp_b;
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = 6'(len);
    tick();
    cmd_valid = 1'b0;
    chk("load_pl_ready", pl_ready, 1);
    chk("load_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < len; i++) begin
      if (gapped && i > 0) begin
        pl_valid = 1'b0;
        tick();
        chk("gap_hold_low", packet_valid, 0);
      end
      pl_valid = 1'b1; pl_data = pl_mem[i];
      tick();
      if (i < len - 1) chk("load_low", packet_valid, 0);
    end
    pl_valid = 1'b0;
    for (int p = 0; p <= len; p++) begin
      exp_b = (p == 0) ? hdr : pl_mem[p-1];
      chk("stream_valid", packet_valid, 1);
      chk("stream_data", pkt_data, exp_b);
      if (p == stall_pos) begin
        busy = 1'b1;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          chk("stall_valid", packet_valid, 1);
          chk("stall_data", pkt_data, exp_b);
        end
        busy = 1'b0;
      end
      tick();
    end
    chk("par_valid", packet_valid, 0);
    chk("par_data", pkt_data, par);
    chk("par_no_done", done, 0);
    tick();
    exp_cnt++;
    chk("done_pulse", done, 1);
    chk("done_data", pkt_data, 0);
    chk("pkt_cnt", pkt_cnt, exp_cnt);
    chk("pkt_cnt_wrap", pkt_cnt_w, exp_cnt % 4);
    tick();
    chk("done_one_cycle", done, 0);
    chk("gap_not_ready", cmd_ready, 0);
    chk("gap_valid_low", packet_valid, 0);
    tick();
    chk("gap_done_ready", cmd_ready, 1);
  endtask

  task automatic reject(input logic [1:0] a, input logic [5:0] l);
    chk("rej_ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
    chk("rej_err", cmd_err, 1);
    chk("rej_ready", cmd_ready, 1);
    chk("rej_valid", packet_valid, 0);
    tick();
    chk("rej_err_one", cmd_err, 0);
    chk("rej_ready_post", cmd_ready, 1);
    chk("rej_cnt", pkt_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
    repeat (3) tick();
    chk("rst_valid", packet_valid, 0);
    chk("rst_data", pkt_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_cnt", pkt_cnt, 0);
    #2 reset = 1'b0;
    tick();
    chk("rst_idle_ready", cmd_ready, 1);
    chk("rst_pl_ready", pl_ready, 0);

    // Basic send: hdr 0x09, parity 0x09^0xAA^0x55 = 0xF6
    pl_mem[0] = 8'hAA; pl_mem[1] = 8'h55;
    run_pkt(2'd1, 2, 1'b0, -1, 0, 8'h09, 8'hF6);

    // Busy stall on the first payload byte (held 4 cycles total)
    run_pkt(2'd1, 2, 1'b0, 1, 3, 8'h09, 8'hF6);

    // Rejected commands
    reject(2'd3, 6'd4);
    reject(2'd0, 6'd0);

    // Gapped payload: hdr 0x16, parity 0x16^11^22^33^44^55 = 0x07
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
    pl_mem[3] = 8'h44; pl_mem[4] = 8'h55;
    run_pkt(2'd2, 5, 1'b1, -1, 0, 8'h16, 8'h07);

    // Max length, payload 0..62: hdr 0xFC, parity 0xFC^0x3F = 0xC3; 2-bit twin wraps 3->0
    for (int i = 0; i < 63; i++) pl_mem[i] = 8'(i);
    run_pkt(2'd0, 63, 1'b0, -1, 0, 8'hFC, 8'hC3);

    // Reset in the middle of the payload phase
    pl_mem[0] = 8'h01; pl_mem[1] = 8'h02; pl_mem[2] = 8'h03; pl_mem[3] = 8'h04;
    cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 6'd4;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pl_valid = 1'b1; pl_data = pl_mem[i];
      tick();
    end
    pl_valid = 1'b0;
    tick();
    chk("mid_pld_valid", packet_valid, 1);
    chk("mid_pld_data", pkt_data, 8'h01);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", packet_valid, 0);
    chk("async_rst_data", pkt_data, 0);
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    tick();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_cnt", pkt_cnt, 0);
    chk("post_rst_valid", packet_valid, 0);

    // Recovery packet: hdr 0x0E, parity 0x0E^A1^B2^C3 = 0xDE
    pl_mem[0] = 8'hA1; pl_mem[1] = 8'hB2; pl_mem[2] = 8'hC3;
    run_pkt(2'd2, 3, 1'b0, -1, 0, 8'h0E, 8'hDE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Synthesizable packet source that sits directly upstream of router_top and drives its packet_valid/datain inputs while honouring busy.
- It takes a command (destination port, payload length) and the payload bytes from a byte stream, and buffers the whole payload internally.
- It then emits one contiguous router packet: header, payload, then parity.
- It replaces the bench's task-based generator for system-level traffic.

Parameters:
- LEN_W, 6, payload-length width; buffer depth is 2**LEN_W-1 (63 bytes).
- GAP_CYC, 2, minimum idle cycles with packet_valid=0 after each parity byte is consumed.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted on an edge where cmd_valid&cmd_ready.
- cmd_addr  input  2  destination port (0..2).
- cmd_len  input  LEN_W  payload byte count.
- cmd_err  output  1  one-cycle pulse: command rejected.
- pl_data  input  8  payload byte.
- pl_valid  input  1  payload byte present.
- pl_ready  output  1  payload byte accepted on an edge where pl_valid&pl_ready.
- busy  input  1  router busy; the current byte is held while busy is high.
- packet_valid  output  1  to router packet_valid.
- pkt_data  output  8  to router datain.
- done  output  1  one-cycle pulse on the edge the parity byte is consumed.
- pkt_cnt  output  CNT_W  packets sent; wraps from all-ones to 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; packet_valid=0, pkt_data=0, done=0, cmd_err=0, pkt_cnt=0. Byte counters and parity are cleared. Buffer contents are don't-care.
- Output timing: all outputs are registered except cmd_ready and pl_ready.
  - cmd_ready = (state==IDLE).
  - pl_ready = (state==LOAD).
- Packet format:
  - header = {cmd_len, cmd_addr}; with LEN_W=6 this is 8 bits.
  - Parity = XOR of the header and every payload byte.
- Byte consumption: in HDR, PLD and PAR, a byte is consumed at a rising edge where busy==0. While busy==1, packet_valid and pkt_data hold their values.
- States:
  - IDLE:
    - On cmd_valid with cmd_addr==3 or cmd_len==0: cmd_err=1 for one cycle, stay in IDLE, no packet is emitted.
    - On any other cmd_valid: latch addr and len, set parity=header, rd/wr counters=0, go to LOAD.
  - LOAD:
    - Each accepted pl byte is written to buf[wr] and XORed into parity; wr increments.
    - On the edge that accepts byte number len: packet_valid<=1, pkt_data<=header, go to HDR.
    - Payload bytes may arrive with gaps; gaps are absorbed here and never reach the router.
  - HDR: when the header is consumed, pkt_data<=buf[0], go to PLD.
  - PLD:
    - When a byte is consumed and rd<len-1: pkt_data<=buf[rd+1], rd increments.
    - When the last byte is consumed: packet_valid<=0, pkt_data<=final parity, go to PAR.
  - PAR: when the parity byte is consumed: done=1 for one cycle, pkt_cnt increments, pkt_data<=0, go to GAP.
  - GAP: count GAP_CYC cycles with packet_valid=0, then go to IDLE.
- Contiguity: packet_valid never drops between header and last payload byte. The router reads a low packet_valid as the parity byte.
- Command back-pressure: commands arriving in any state other than IDLE are not accepted (cmd_ready=0). They are not lost; the sender holds them.
- Reset mid-packet: packet_valid falls asynchronously and the partial packet is abandoned. Recovering the router is the system reset's job.
- Back-to-back commands: the second header is emitted no earlier than GAP_CYC+1 cycles after done. Its payload load time adds to that delay.

Test Plan:
- Basic send: cmd addr=1, len=2; payload 0xAA, 0x55; busy=0.
  - Response: header 0x09 with packet_valid=1, then 0xAA and 0x55 on consecutive cycles, then 0xF6 with packet_valid=0.
  - done pulses; pkt_cnt=1.
- Busy stall: as the basic send, but busy=1 for 3 cycles while 0xAA is presented.
  - Response: 0xAA is held 4 cycles with packet_valid=1, then the sequence continues unchanged; parity is 0xF6.
- Reject: cmd addr=3, len=4 → cmd_err is high for exactly 1 cycle, cmd_ready stays 1, packet_valid stays 0, pkt_cnt is unchanged. Repeat with addr=0, len=0 → same response.
- Gapped payload: len=5, addr=2, pl_valid toggling every other cycle.
  - Response: after the 5th byte, packet_valid is continuously high for header + 5 bytes with no gaps.
  - Header is 0x16; parity equals the XOR of the header and the payload.
- Max length and counter wrap:
  - len=63 → 63 payload bytes sent in buffer order.
  - Preload pkt_cnt to 0xFFFF via repeated packets or force → next done gives pkt_cnt=0.
- Reset mid-packet: assert reset during PLD → packet_valid=0 and pkt_data=0 immediately (asynchronously). After release: IDLE, cmd_ready=1, and a new packet is sent correctly.
